// File: rtl/decode_buffer_if.sv
// Fetch/execute handshake bundle for decode_buffer: fetch push side, execute pop side,
// flush/interrupt controls and the decoded head fields.
interface decode_buffer_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            instr_valid_in;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            ready_out;
  logic            valid_out;
  logic            ready_in;
  logic            flush_in;
  logic            interrupt_in;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1_out;
  logic [4:0]      rs2_out;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] imm_value_out;
  logic [2:0]      imm_fmt_out;
  logic            illegal_out;
  logic            irq_taken_out;
  logic [XLEN-1:0] irq_pc_out;
  logic [CW-1:0]   count_out;

  modport slave (
    input  instr_valid_in, instr_in, pc_in, ready_in, flush_in, interrupt_in,
    output ready_out, valid_out, instr_out, pc_out, rs1_out, rs2_out, rd_out,
           imm_value_out, imm_fmt_out, illegal_out, irq_taken_out, irq_pc_out, count_out
  );

  modport master (
    output instr_valid_in, instr_in, pc_in, ready_in, flush_in, interrupt_in,
    input  ready_out, valid_out, instr_out, pc_out, rs1_out, rs2_out, rd_out,
           imm_value_out, imm_fmt_out, illegal_out, irq_taken_out, irq_pc_out, count_out
  );
endinterface

// File: rtl/decode_buffer.sv
// Instruction queue between fetch and execute with zero-latency head decode,
// flush, and edge-triggered interrupt acceptance that captures the resume PC.
module decode_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  decode_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            irq_q;
  logic            irq_taken;
  logic [XLEN-1:0] irq_pc;

  logic            ready;
  logic            valid;
  logic            push;
  logic            pop;
  logic            irq_edge;
  logic            clear;

  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic [6:0]      opcode;
  imm_fmt_e        fmt;
  logic signed [31:0] imm32;

  assign ready    = (count < CW'(DEPTH));
  assign valid    = (count != '0);
  assign push     = bus.instr_valid_in && ready;
  assign pop      = valid && bus.ready_in;
  assign irq_edge = bus.interrupt_in && !irq_q;
  // An interrupt edge empties the queue exactly like a flush.
  assign clear    = bus.flush_in || irq_edge;

  // NOTE: entry storage has no reset; count/pointers alone decide what is valid.
  always_ff @(posedge clk_in) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]    <= bus.pc_in;
      instr_mem[wr_ptr] <= bus.instr_in;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      irq_q     <= 1'b0;
      irq_taken <= 1'b0;
      irq_pc    <= '0;
    end else begin
      irq_q     <= bus.interrupt_in;
      irq_taken <= irq_edge;
      if (irq_edge) begin
        if (valid) begin
          irq_pc <= head_pc;
        end else if (bus.instr_valid_in) begin
          irq_pc <= bus.pc_in;
        end
      end

      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign opcode     = head_instr[6:0];

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    fmt   = FMT_NONE;
    imm32 = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        fmt   = FMT_I;
        imm32 = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = FMT_B;
        imm32 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                 head_instr[30:25], head_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = FMT_U;
        imm32 = {head_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt   = FMT_J;
        imm32 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                 head_instr[20], head_instr[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  assign bus.ready_out     = ready;
  assign bus.valid_out     = valid;
  assign bus.count_out     = count;
  assign bus.instr_out     = head_instr;
  assign bus.pc_out        = head_pc;
  assign bus.rs1_out       = head_instr[19:15];
  assign bus.rs2_out       = head_instr[24:20];
  assign bus.rd_out        = head_instr[11:7];
  assign bus.imm_value_out = XLEN'(imm32);
  assign bus.imm_fmt_out   = fmt;
  assign bus.illegal_out   = valid && (opcode[1:0] != 2'b11);
  assign bus.irq_taken_out = irq_taken;
  assign bus.irq_pc_out    = irq_pc;
endmodule

// File: tb/tb_decode_buffer.sv
// Self-checking bench for decode_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_decode_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference immediate decode written as signed arithmetic on the whole word.
  function automatic void exp_decode(input logic [31:0] i, output logic [2:0] fmt,
                                     output logic [63:0] imm);
    longint s;
    s   = longint'($signed(i));
    fmt = 3'd0;
    imm = 64'd0;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1;
        imm = s >>> 20;
      end
      7'b0100011: begin
        fmt = 3'd2;
        imm = ((s >>> 25) << 5) | longint'(i[11:7]);
      end
      7'b1100011: begin
        fmt = 3'd3;
        imm = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
              | (longint'(i[11:8]) << 1);
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        imm = (s >>> 12) << 12;
      end
      7'b1101111: begin
        fmt = 3'd5;
        imm = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
              | (longint'(i[30:21]) << 1);
      end
      default: begin
        fmt = 3'd0;
        imm = 64'd0;
      end
    endcase
  endfunction

  // Behavioural model state.
  entry_t      mq[$];
  logic        m_irq_q    = 1'b0;
  logic        m_taken    = 1'b0;
  logic [63:0] m_irq_pc   = 64'd0;

  initial begin
    forever begin
      bit do_edge, do_push, do_pop;
      @(posedge clk_in or posedge rst_in);
      if (rst_in) begin
        mq.delete();
        m_irq_q  = 1'b0;
        m_taken  = 1'b0;
        m_irq_pc = 64'd0;
      end else begin
        do_edge = bus.interrupt_in && !m_irq_q;
        do_push = bus.instr_valid_in && (mq.size() < DEPTH);
        do_pop  = (mq.size() != 0) && bus.ready_in;
        m_taken = do_edge;
        if (do_edge) begin
          if (mq.size() != 0) m_irq_pc = mq[0].pc;
          else if (bus.instr_valid_in) m_irq_pc = bus.pc_in;
        end
        m_irq_q = bus.interrupt_in;
        if (bus.flush_in || do_edge) begin
          mq.delete();
        end else begin
          entry_t e;
          e.pc    = bus.pc_in;
          e.instr = bus.instr_in;
          if (do_pop)  void'(mq.pop_front());
          if (do_push) mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      logic [2:0]  efmt;
      logic [63:0] eimm;
      @(negedge clk_in);
      if (!rst_in) begin
        check("count", 64'(bus.count_out), 64'(mq.size()));
        check("valid", 64'(bus.valid_out), 64'(mq.size() != 0));
        check("ready", 64'(bus.ready_out), 64'(mq.size() < DEPTH));
        check("irq_taken", 64'(bus.irq_taken_out), 64'(m_taken));
        check("irq_pc", bus.irq_pc_out, m_irq_pc);
        if (mq.size() != 0) begin
          exp_decode(mq[0].instr, efmt, eimm);
          check("instr", 64'(bus.instr_out), 64'(mq[0].instr));
          check("pc", bus.pc_out, mq[0].pc);
          check("rs1", 64'(bus.rs1_out), 64'(mq[0].instr[19:15]));
          check("rs2", 64'(bus.rs2_out), 64'(mq[0].instr[24:20]));
          check("rd", 64'(bus.rd_out), 64'(mq[0].instr[11:7]));
          check("imm_fmt", 64'(bus.imm_fmt_out), 64'(efmt));
          check("imm_value", bus.imm_value_out, eimm);
          check("illegal", 64'(bus.illegal_out), 64'(mq[0].instr[1:0] != 2'b11));
        end else begin
          check("illegal_empty", 64'(bus.illegal_out), 64'd0);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic r, input logic f, input logic irq);
    bus.instr_valid_in = v;
    bus.instr_in       = i;
    bus.pc_in          = p;
    bus.ready_in       = r;
    bus.flush_in       = f;
    bus.interrupt_in   = irq;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [2:0]  pfmt;
    logic [63:0] pimm;
    int          pulses;
    logic        irq_lvl;
    int          opc [12] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011,
                              7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b0110011, 7'b0000000};

    drive(0, NOP, 64'd0, 0, 0, 0);

    exp_decode(32'hFE00_0EE3, pfmt, pimm);
    check("model_beq_imm", pimm, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_decode(32'h0000_10B7, pfmt, pimm);
    check("model_lui_imm", pimm, 64'h0000_0000_0000_1000);

    // Reset state.
    repeat (3) tick();
    check("rst_count", 64'(bus.count_out), 64'd0);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_ready", 64'(bus.ready_out), 64'd1);
    check("rst_irq_taken", 64'(bus.irq_taken_out), 64'd0);
    check("rst_irq_pc", bus.irq_pc_out, 64'd0);
    rst_in = 1'b0;
    tick();

    // Fill with ready_in low, drop a fifth offer, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(1, NOP, 64'h100 + 64'(4 * k), 0, 0, 0);
      tick();
    end
    check("fill_count", 64'(bus.count_out), 64'd4);
    check("fill_ready", 64'(bus.ready_out), 64'd0);
    drive(1, NOP, 64'h110, 0, 0, 0);
    tick();
    check("fifth_dropped", 64'(bus.count_out), 64'd4);
    drive(0, NOP, 64'd0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", bus.pc_out, 64'h100 + 64'(4 * k));
      tick();
    end
    check("drain_empty", 64'(bus.valid_out), 64'd0);

    // Streaming push+pop across pointer wrap.
    drive(1, NOP, 64'h2FC, 1, 0, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      check("stream_pc", bus.pc_out, 64'h2FC + 64'(4 * k));
      drive(1, NOP, 64'h300 + 64'(4 * k), 1, 0, 0);
      tick();
      check("stream_count", 64'(bus.count_out), 64'd1);
    end
    drive(0, NOP, 64'd0, 1, 0, 0);
    tick();

    // Immediate decode of addi -1 then beq -4.
    drive(1, 32'hFFF0_0093, 64'h400, 0, 0, 0);
    tick();
    check("addi_fmt", 64'(bus.imm_fmt_out), 64'd1);
    check("addi_imm", bus.imm_value_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_rd", 64'(bus.rd_out), 64'd1);
    drive(1, 32'hFE00_0EE3, 64'h404, 1, 0, 0);
    tick();
    check("beq_fmt", 64'(bus.imm_fmt_out), 64'd3);
    check("beq_imm", bus.imm_value_out, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, NOP, 64'd0, 1, 0, 0);
    tick();

    // Flush with a same-cycle push.
    for (int k = 0; k < 3; k++) begin
      drive(1, NOP, 64'h500 + 64'(4 * k), 0, 0, 0);
      tick();
    end
    check("pre_flush_count", 64'(bus.count_out), 64'd3);
    drive(1, NOP, 64'h50C, 0, 1, 0);
    tick();
    check("flush_count", 64'(bus.count_out), 64'd0);
    check("flush_valid", 64'(bus.valid_out), 64'd0);
    drive(0, NOP, 64'd0, 0, 0, 0);
    tick();

    // Interrupt edge with head pc 0x200, level then held.
    drive(1, NOP, 64'h200, 0, 0, 0);
    tick();
    drive(0, NOP, 64'd0, 0, 0, 1);
    tick();
    check("irq_pulse", 64'(bus.irq_taken_out), 64'd1);
    check("irq_pc_200", bus.irq_pc_out, 64'h200);
    check("irq_empty", 64'(bus.count_out), 64'd0);
    pulses = int'(bus.irq_taken_out);
    repeat (5) begin
      tick();
      pulses += int'(bus.irq_taken_out);
    end
    check("irq_pulse_total", 64'(pulses), 64'd1);
    drive(0, NOP, 64'd0, 0, 0, 0);
    tick();

    // Asynchronous reset between edges.
    for (int k = 0; k < 2; k++) begin
      drive(1, NOP, 64'h600 + 64'(4 * k), 0, 0, 0);
      tick();
    end
    check("pre_rst_count", 64'(bus.count_out), 64'd2);
    drive(0, NOP, 64'd0, 0, 0, 0);
    rst_in = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.valid_out), 64'd0);
    check("async_rst_count", 64'(bus.count_out), 64'd0);
    #1;
    rst_in = 1'b0;
    drive(1, NOP, 64'h700, 0, 0, 0);
    tick();
    check("post_rst_push", 64'(bus.count_out), 64'd1);
    drive(0, NOP, 64'd0, 1, 0, 0);
    tick();

    // Randomized traffic against the model.
    irq_lvl = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] ins;
      logic [63:0] pcv;
      ins = {$urandom()} & 32'hFFFF_FF80;
      ins = ins | 32'(opc[$urandom_range(0, 11)]);
      if ($urandom_range(0, 9) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      pcv = {32'($urandom()), 32'($urandom())} & ~64'h3;
      if ($urandom_range(0, 99) < 6) irq_lvl = ~irq_lvl;
      drive($urandom_range(0, 99) < 70, ins, pcv, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 3, irq_lvl);
      tick();
    end

    drive(0, NOP, 64'd0, 0, 1, 0);
    tick();
    drive(0, NOP, 64'd0, 0, 0, 0);
    tick();
    @(negedge clk_in);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
